pc_fetch_ctrl: RTL
==================

// Module: pc_fetch_ctrl
// PURPOSE
//  Drives the PCEN/new_pc inputs of the program counter and consumes its PC/npc outputs.
//  Issues instruction-memory reads at PC and holds the fetched word until the datapath
//  accepts it. Selects the next PC (sequential npc, or a redirect target from the
//  branch/jump logic). Stops fetching on halt.
//  Sits between the program counter, the instruction side of the cache and the datapath.
// PARAMETERS
//  WORD_W  32  width of PC, npc, new_pc, addresses and instruction words
//  CNT_W   32  width of the retired-instruction counter
// PORTS
//  CLK           in   1       system clock, rising edge
//  nRST          in   1       reset, asynchronous, active-low
//  PC            in   WORD_W  current PC from program counter
//  npc           in   WORD_W  PC+4 from program counter
//  ihit          in   1       imem read complete; imemload valid this cycle
//  imemload      in   WORD_W  instruction word read from memory
//  dp_ready      in   1       datapath accepts instr this cycle
//  redir_valid   in   1       branch taken / jump for the instruction being accepted
//  redir_target  in   WORD_W  redirect target address
//  halt          in   1       instruction being accepted is HALT
//  imemREN       out  1       instruction read enable
//  imemaddr      out  WORD_W  instruction read address
//  instr         out  WORD_W  held instruction word to datapath
//  instr_valid   out  1       instr is valid and awaiting dp_ready
//  PCEN          out  1       PC load enable, one-cycle pulse
//  new_pc        out  WORD_W  value loaded into PC when PCEN=1
//  halted        out  1       fetch permanently stopped
//  retired       out  CNT_W   count of PCEN pulses
// BEHAVIOUR
//  Clock and reset: one clock, CLK. nRST is asynchronous and active-low.
//  Reset values: state=BOOT. imemREN, instr_valid, PCEN and halted are 0.
//    imemaddr, instr, new_pc and retired are 0.
//  Reset asserted mid-fetch or mid-issue aborts immediately. No PCEN pulse is produced.
//  States:
//    BOOT: outputs idle; next cycle goes to FETCH.
//    FETCH: imemREN=1, imemaddr=PC (combinational).
//      On ihit: instr<=imemload, instr_valid<=1, state->ISSUE.
//      Otherwise stay in FETCH. There is no timeout.
//    ISSUE: imemREN=0; instr and instr_valid are held stable until dp_ready.
//      With dp_ready=1 and halt=0: PCEN=1 (combinational, same cycle), instr_valid<=0,
//        retired<=retired+1 (wraps at 2^CNT_W), state->FETCH.
//        new_pc = redir_valid ? redir_target : npc.
//      With dp_ready=1 and halt=1: PCEN=0, halted<=1, instr_valid<=0, state->HALTED.
//        halt has priority over redir_valid.
//      With dp_ready=0: no change.
//    HALTED: all enables 0; remains until nRST.
//  new_pc[1:0] is always forced to 2'b00 (word alignment), including redirect targets.
//  When PCEN=0, new_pc holds its last driven value, so it is never X.
//  redir_valid, redir_target and halt are sampled only in ISSUE with dp_ready=1.
//    They are ignored in every other state.
//  ihit outside FETCH is ignored. A spurious ihit must not overwrite instr.
//  Latency: minimum 2 cycles per instruction.
//    ihit in cycle t -> instr_valid=1 in t+1.
//    dp_ready in t+1 -> PCEN pulse in t+1, PC updates at end of t+1, FETCH in t+2.
//  PCEN is never high for 2 consecutive cycles.
// TESTING
//  1. Reset, then PC=0x0 and ihit on the first FETCH cycle with imemload=0x20010005, then dp_ready
//     -> imemaddr=0x0, instr=0x20010005, one PCEN pulse with new_pc=0x4, retired=1.
//  2. ihit delayed 5 cycles -> imemREN=1 and imemaddr stable for all 5 cycles;
//     PCEN stays 0 until dp_ready in ISSUE.
//  3. In ISSUE, redir_valid=1, redir_target=0x00000103, dp_ready=1
//     -> new_pc=0x00000100 and PCEN=1 in the same cycle.
//  4. dp_ready held low 3 cycles in ISSUE with ihit toggling
//     -> instr unchanged, instr_valid=1, PCEN=0 throughout.
//  5. halt=1 together with redir_valid=1 and dp_ready=1
//     -> PCEN=0, halted=1 next cycle, imemREN=0 afterwards, retired unchanged.
//  6. nRST pulsed low while waiting in FETCH
//     -> outputs return to reset values asynchronously; no PCEN pulse; retired=0.

Source files
------------

// File: rtl/pc_fetch_ctrl_if.sv
// Purpose: groups the fetch controller's bus-side signals. These cover the
//   program counter (PC/npc in, PCEN/new_pc out), the instruction read port
//   (imemREN/imemaddr out, ihit/imemload in), and the datapath issue port
//   (instr/instr_valid out, dp_ready/redir_*/halt in).
// Modports:
//   master - the fetch controller (pc_fetch_ctrl)
//   slave  - everything around it (PC register, imem, datapath, testbench)
interface pc_fetch_ctrl_if #(
    parameter int WORD_W = 32,
    parameter int CNT_W  = 32
);
    logic [WORD_W-1:0] PC;
    logic [WORD_W-1:0] npc;
    logic              ihit;
    logic [WORD_W-1:0] imemload;
    logic              dp_ready;
    logic              redir_valid;
    logic [WORD_W-1:0] redir_target;
    logic              halt;
    logic              imemREN;
    logic [WORD_W-1:0] imemaddr;
    logic [WORD_W-1:0] instr;
    logic              instr_valid;
    logic              PCEN;
    logic [WORD_W-1:0] new_pc;
    logic              halted;
    logic [CNT_W-1:0]  retired;

    modport master (
        input  PC, npc, ihit, imemload, dp_ready, redir_valid, redir_target, halt,
        output imemREN, imemaddr, instr, instr_valid, PCEN, new_pc, halted, retired
    );

    modport slave (
        output PC, npc, ihit, imemload, dp_ready, redir_valid, redir_target, halt,
        input  imemREN, imemaddr, instr, instr_valid, PCEN, new_pc, halted, retired
    );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Purpose: instruction fetch sequencer. It reads imem at PC, holds the fetched
//   word until the datapath takes it, and then pulses PCEN with the next PC.
//   The next PC is either the sequential npc or a redirect target. Fetching
//   stops for good on HALT.
// Ports:
//   CLK  - system clock, rising edge
//   nRST - asynchronous active-low reset
//   bus  - pc_fetch_ctrl_if.master (PC/imem/datapath signals)
//
// state  | meaning
// BOOT   | just out of reset, outputs idle
// FETCH  | imem read at PC in flight, waiting for ihit
// ISSUE  | instr held valid, waiting for dp_ready
// HALTED | HALT accepted, fetch stopped until reset
module pc_fetch_ctrl #(
    parameter int WORD_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic           CLK,
    input  logic           nRST,
    pc_fetch_ctrl_if.master bus
);
    localparam logic [1:0] BOOT   = 2'd0;
    localparam logic [1:0] FETCH  = 2'd1;
    localparam logic [1:0] ISSUE  = 2'd2;
    localparam logic [1:0] HALTED = 2'd3;

    logic [1:0]        state, state_d;
    logic [WORD_W-1:0] instr_q;
    logic              instr_valid_q;
    logic              halted_q;
    logic [CNT_W-1:0]  retired_q;
    logic [WORD_W-1:0] new_pc_q;

    logic              accept;
    logic              fire;
    logic              stop;
    logic [WORD_W-1:0] next_pc;

    // A PC load happens only when the datapath accepts a non-HALT instruction.
    // The redirect and halt inputs are therefore looked at in that cycle only.
    assign accept  = (state == ISSUE) && bus.dp_ready;
    assign fire    = accept && !bus.halt;
    assign stop    = accept && bus.halt;
    assign next_pc = (bus.redir_valid ? bus.redir_target : bus.npc)
                     & ~WORD_W'(3);

    always_comb begin
        state_d = state;
        case (state)
            BOOT:    state_d = FETCH;
            FETCH:   if (bus.ihit) state_d = ISSUE;
            ISSUE: begin
                if (fire)      state_d = FETCH;
                else if (stop) state_d = HALTED;
            end
            default: state_d = HALTED;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state         <= BOOT;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
            retired_q     <= '0;
            new_pc_q      <= '0;
        end else begin
            state <= state_d;
            // ihit is only honoured in FETCH, so a stray hit can't clobber instr.
            if (state == FETCH && bus.ihit) begin
                instr_q       <= bus.imemload;
                instr_valid_q <= 1'b1;
            end
            if (accept) begin
                instr_valid_q <= 1'b0;
            end
            if (fire) begin
                retired_q <= retired_q + 1'b1;
                new_pc_q  <= next_pc;
            end
            if (stop) begin
                halted_q <= 1'b1;
            end
        end
    end

    assign bus.imemREN     = (state == FETCH);
    assign bus.imemaddr    = (state == FETCH) ? bus.PC : '0;
    assign bus.instr       = instr_q;
    assign bus.instr_valid = instr_valid_q;
    assign bus.PCEN        = fire;
    // new_pc shows the live value during the PCEN cycle. At all other times it
    // shows the last loaded value, so it is never X.
    assign bus.new_pc      = fire ? next_pc : new_pc_q;
    assign bus.halted      = halted_q;
    assign bus.retired     = retired_q;
endmodule
